// File: rtl/norm_round_pack.sv
// Two-stage normalise / round / pack for BF16, FP8 (E4M3) and INT4 sums.
// Define NORM_ROUND_RNE_EN for round-to-nearest-even; the default build truncates.
module norm_round_pack #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [15:0]      sum_bf,
  input  logic             cout_bf,
  input  logic [7:0]       e_bfmax,
  input  logic [7:0]       s_fp,
  input  logic             c_fp,
  input  logic [3:0]       e_fpmax,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_inv,
  output logic [CNT_W-1:0] sat_count
);

  localparam int unsigned BF_M_W    = 17;
  localparam int unsigned BF_L_W    = 5;
  localparam int unsigned BF_E_W    = 10;
  localparam int unsigned BF_MANT_W = 7;
  localparam int unsigned FP_M_W    = 9;
  localparam int unsigned FP_L_W    = 4;
  localparam int unsigned FP_E_W    = 6;
  localparam int unsigned FP_MANT_W = 3;

`ifdef NORM_ROUND_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    MODE_BF16 = 2'b00,
    MODE_FP8  = 2'b01,
    MODE_RSVD = 2'b10,
    MODE_INT4 = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e              mode;
    logic               sign;
    logic [BF_M_W-1:0]  mag_bf;
    logic [7:0]         e_bf;
    logic [BF_L_W-1:0]  lead_bf;
    logic [FP_M_W-1:0]  mag_fp;
    logic [3:0]         e_fp;
    logic [FP_L_W-1:0]  lead_fp;
  } s1_t;

  // Position of the most significant set bit (0 when the value is zero).
  function automatic logic [BF_L_W-1:0] lead_one_bf(input logic [BF_M_W-1:0] v);
    lead_one_bf = '0;
    for (int i = 0; i < int'(BF_M_W); i++) begin
      if (v[i]) lead_one_bf = BF_L_W'(i);
    end
  endfunction

  function automatic logic [FP_L_W-1:0] lead_one_fp(input logic [FP_M_W-1:0] v);
    lead_one_fp = '0;
    for (int i = 0; i < int'(FP_M_W); i++) begin
      if (v[i]) lead_one_fp = FP_L_W'(i);
    end
  endfunction

  // Handshake: stage 2 frees when empty or draining; stage 1 frees when empty or moving on.
  logic s1_valid;
  logic s2_adv;
  logic s1_load;
  logic s2_load;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_adv;

  s1_t s1_d;
  s1_t s1_q;

  always_comb begin
    s1_d         = '0;
    s1_d.mode    = mode_e'(mode);
    s1_d.sign    = sign_in;
    s1_d.mag_bf  = {cout_bf, sum_bf};
    s1_d.e_bf    = e_bfmax;
    s1_d.lead_bf = lead_one_bf({cout_bf, sum_bf});
    s1_d.mag_fp  = {c_fp, s_fp};
    s1_d.e_fp    = e_fpmax;
    s1_d.lead_fp = lead_one_fp({c_fp, s_fp});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (s1_load) s1_q <= s1_d;
    end
  end

  // BF16 datapath: leading one lands on bit 16 after the shift.
  logic [BF_M_W-1:0]      bf_norm;
  logic [BF_MANT_W-1:0]   bf_mant;
  logic                   bf_guard;
  logic                   bf_sticky;
  logic                   bf_inc;
  logic [BF_MANT_W:0]     bf_rnd;
  logic signed [BF_E_W-1:0] bf_exp;

  assign bf_norm   = s1_q.mag_bf << (BF_L_W'(BF_M_W - 1) - s1_q.lead_bf);
  assign bf_mant   = bf_norm[15:9];
  assign bf_guard  = bf_norm[8];
  assign bf_sticky = |bf_norm[7:0];
  assign bf_inc    = RNE_EN & bf_guard & (bf_sticky | bf_mant[0]);
  assign bf_rnd    = {1'b0, bf_mant} + (BF_MANT_W + 1)'(bf_inc);
  assign bf_exp    = BF_E_W'(s1_q.e_bf) + BF_E_W'(s1_q.lead_bf)
                   + BF_E_W'(bf_rnd[BF_MANT_W]) - BF_E_W'(14);

  // FP8 datapath: leading one lands on bit 8 after the shift.
  logic [FP_M_W-1:0]      fp_norm;
  logic [FP_MANT_W-1:0]   fp_mant;
  logic                   fp_guard;
  logic                   fp_sticky;
  logic                   fp_inc;
  logic [FP_MANT_W:0]     fp_rnd;
  logic signed [FP_E_W-1:0] fp_exp;

  assign fp_norm   = s1_q.mag_fp << (FP_L_W'(FP_M_W - 1) - s1_q.lead_fp);
  assign fp_mant   = fp_norm[7:5];
  assign fp_guard  = fp_norm[4];
  assign fp_sticky = |fp_norm[3:0];
  assign fp_inc    = RNE_EN & fp_guard & (fp_sticky | fp_mant[0]);
  assign fp_rnd    = {1'b0, fp_mant} + (FP_MANT_W + 1)'(fp_inc);
  assign fp_exp    = FP_E_W'(s1_q.e_fp) + FP_E_W'(s1_q.lead_fp)
                   + FP_E_W'(fp_rnd[FP_MANT_W]) - FP_E_W'(6);

  logic [15:0] res_data;
  logic        res_ovf;
  logic        res_unf;
  logic        res_inv;

  // Exception checks use the exponent after any rounding carry.
  always_comb begin
    res_data = '0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    res_inv  = 1'b0;
    case (s1_q.mode)
      MODE_BF16: begin
        if (!bf_norm[BF_M_W-1]) begin
          res_data = {s1_q.sign, 15'h0};
        end else if (bf_exp >= 10'sd255) begin
          res_data = {s1_q.sign, 8'hFF, 7'h0};
          res_ovf  = 1'b1;
        end else if (bf_exp <= 10'sd0) begin
          res_data = {s1_q.sign, 15'h0};
          res_unf  = 1'b1;
        end else begin
          res_data = {s1_q.sign, bf_exp[7:0], bf_rnd[BF_MANT_W-1:0]};
        end
      end
      MODE_FP8: begin
        if (!fp_norm[FP_M_W-1]) begin
          res_data = {8'h00, s1_q.sign, 7'h0};
        end else if ((fp_exp > 6'sd15) ||
                     ((fp_exp == 6'sd15) && (fp_rnd[FP_MANT_W-1:0] == 3'b111))) begin
          res_data = {8'h00, s1_q.sign, 4'hF, 3'b110};
          res_ovf  = 1'b1;
        end else if (fp_exp <= 6'sd0) begin
          res_data = {8'h00, s1_q.sign, 7'h0};
          res_unf  = 1'b1;
        end else begin
          res_data = {8'h00, s1_q.sign, fp_exp[3:0], fp_rnd[FP_MANT_W-1:0]};
        end
      end
      MODE_INT4: begin
        res_data = {7'h0, s1_q.mag_fp};
      end
      default: begin
        res_inv = 1'b1;
      end
    endcase
  end

  // Output stage holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
      out_inv   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s2_load) begin
        out_data <= res_data;
        out_ovf  <= res_ovf;
        out_unf  <= res_unf;
        out_inv  <= res_inv;
      end
    end
  end

  // Saturating count of overflow results actually handed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_ovf && !(&sat_count)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_norm_round_pack.sv
// Self-checking bench for norm_round_pack: vector table, directed stall/reset
// sequences and randomized traffic against an arithmetic reference model.
module tb_norm_round_pack;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned NV    = 22;

`ifdef NORM_ROUND_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
    logic        unf;
    logic        inv;
  } res_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic        sign;
    logic        cbf;
    logic [15:0] sbf;
    logic [7:0]  ebf;
    logic        cfp;
    logic [7:0]  sfp;
    logic [3:0]  efp;
  } beat_t;

  typedef struct {
    beat_t b;
    res_t  r;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic             sign_in;
  logic [15:0]      sum_bf;
  logic             cout_bf;
  logic [7:0]       e_bfmax;
  logic [7:0]       s_fp;
  logic             c_fp;
  logic [3:0]       e_fpmax;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_ovf;
  logic             out_unf;
  logic             out_inv;
  logic [CNT_W-1:0] sat_count;

  norm_round_pack #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .sum_bf    (sum_bf),
    .cout_bf   (cout_bf),
    .e_bfmax   (e_bfmax),
    .s_fp      (s_fp),
    .c_fp      (c_fp),
    .e_fpmax   (e_fpmax),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_inv   (out_inv),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  res_t out_r;
  assign out_r = {out_data, out_ovf, out_unf, out_inv};

  int               n_tests = 0;
  int               n_fail  = 0;
  res_t             q[$];
  logic [CNT_W-1:0] exp_sat = '0;
  logic [CNT_W-1:0] sat_max = '1;
  logic             prev_stall = 1'b0;
  res_t             held;
  vec_t             vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] s);
    return (s == sat_max) ? s : CNT_W'(s + 1'b1);
  endfunction

  // Reference: value = mag * 2^(e0 - pt); pick leading one, divide, round on remainder.
  function automatic res_t model(input beat_t b);
    res_t   r;
    longint mag, scaled, qt, rem, half2;
    int     lead, mb, pt, e, m;
    r = '0;
    if (b.mode == 2'b10) begin
      r.inv = 1'b1;
      return r;
    end
    if (b.mode == 2'b11) begin
      r.data = {7'h0, b.cfp, b.sfp};
      return r;
    end
    if (b.mode == 2'b00) begin
      mag = longint'({b.cbf, b.sbf}); mb = 7; pt = 14; e = int'(b.ebf);
    end else begin
      mag = longint'({b.cfp, b.sfp}); mb = 3; pt = 6;  e = int'(b.efp);
    end
    if (mag == 0) begin
      r.data = (b.mode == 2'b00) ? {b.sign, 15'h0} : {8'h00, b.sign, 7'h0};
      return r;
    end
    lead = 0;
    while ((mag >> (lead + 1)) != 0) lead++;
    scaled = mag << mb;
    qt     = scaled >> lead;
    rem    = scaled - (qt << lead);
    half2  = longint'(1) << lead;
    if (RNE && ((2 * rem > half2) || ((2 * rem == half2) && (qt % 2 == 1)))) qt++;
    e = e + lead - pt;
    if (qt == (longint'(2) << mb)) begin
      qt = longint'(1) << mb;
      e++;
    end
    m = int'(qt - (longint'(1) << mb));
    if (b.mode == 2'b00) begin
      if (e >= 255) begin
        r.data = {b.sign, 8'hFF, 7'h0}; r.ovf = 1'b1;
      end else if (e <= 0) begin
        r.data = {b.sign, 15'h0}; r.unf = 1'b1;
      end else begin
        r.data = {b.sign, 8'(e), 7'(m)};
      end
    end else begin
      if ((e > 15) || (e == 15 && m == 7)) begin
        r.data = {8'h00, b.sign, 4'hF, 3'b110}; r.ovf = 1'b1;
      end else if (e <= 0) begin
        r.data = {8'h00, b.sign, 7'h0}; r.unf = 1'b1;
      end else begin
        r.data = {8'h00, b.sign, 4'(e), 3'(m)};
      end
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [1:0] md, input logic sg, input logic cb,
                              input logic [15:0] sb, input logic [7:0] eb, input logic cf,
                              input logic [7:0] sf, input logic [3:0] ef, input logic [15:0] d,
                              input logic ov, input logic un, input logic iv);
    vec_t v;
    v.b.mode = md; v.b.sign = sg; v.b.cbf = cb; v.b.sbf = sb; v.b.ebf = eb;
    v.b.cfp = cf;  v.b.sfp = sf;  v.b.efp = ef;
    v.r.data = d;  v.r.ovf = ov;  v.r.unf = un; v.r.inv = iv;
    return v;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.mode = 2'($urandom);
    b.sign = 1'($urandom);
    b.cbf  = ($urandom % 4 == 0);
    b.sbf  = 16'($urandom);
    b.sbf  = b.sbf >> $urandom_range(0, 16);
    case ($urandom % 3)
      0:       b.ebf = 8'($urandom_range(0, 16));
      1:       b.ebf = 8'($urandom_range(236, 255));
      default: b.ebf = 8'($urandom);
    endcase
    b.cfp = ($urandom % 4 == 0);
    b.sfp = 8'($urandom);
    b.sfp = b.sfp >> $urandom_range(0, 8);
    b.efp = 4'($urandom);
    return b;
  endfunction

  task automatic set_in(input beat_t b);
    mode = b.mode; sign_in = b.sign; cout_bf = b.cbf; sum_bf = b.sbf; e_bfmax = b.ebf;
    c_fp = b.cfp;  s_fp = b.sfp;     e_fpmax = b.efp;
  endtask

  // One cycle from just after a negedge: scoreboard, hold and counter checks.
  task automatic tick(input res_t e_push);
    res_t r;
    #1;
    check("sat_count", 32'(sat_count), 32'(exp_sat));
    if (prev_stall) check("stall_hold", 32'({out_valid, out_r}), 32'({1'b1, held}));
    prev_stall = out_valid && !out_ready;
    held       = out_r;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h, expected no beat at %0t", out_r, $time);
      end else begin
        r = q.pop_front();
        check("result", 32'(out_r), 32'(r));
        if (r.ovf) exp_sat = sat_inc(exp_sat);
      end
    end
    if (in_valid && in_ready) q.push_back(e_push);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    beat_t sb[4];
    int    k;
    bit    acc;

    vecs[0]  = mk(2'b00, 0, 0, 16'h4000, 8'd127, 0, 8'h00, 4'd0, 16'h3F80, 0, 0, 0);
    vecs[1]  = mk(2'b00, 0, 1, 16'h0000, 8'd254, 0, 8'h00, 4'd0, 16'h7F80, 1, 0, 0);
`ifdef NORM_ROUND_RNE_EN
    vecs[2]  = mk(2'b01, 0, 0, 16'h0000, 8'd0,   0, 8'h4C, 4'd7, 16'h003A, 0, 0, 0);
    vecs[12] = mk(2'b00, 0, 0, 16'h7FFF, 8'd127, 0, 8'h00, 4'd0, 16'h4000, 0, 0, 0);
    vecs[13] = mk(2'b00, 0, 1, 16'hFFFF, 8'd252, 0, 8'h00, 4'd0, 16'h7F80, 1, 0, 0);
`else
    vecs[2]  = mk(2'b01, 0, 0, 16'h0000, 8'd0,   0, 8'h4C, 4'd7, 16'h0039, 0, 0, 0);
    vecs[12] = mk(2'b00, 0, 0, 16'h7FFF, 8'd127, 0, 8'h00, 4'd0, 16'h3FFF, 0, 0, 0);
    vecs[13] = mk(2'b00, 0, 1, 16'hFFFF, 8'd252, 0, 8'h00, 4'd0, 16'h7F7F, 0, 0, 0);
`endif
    vecs[3]  = mk(2'b01, 0, 0, 16'h0000, 8'd0,   0, 8'h40, 4'd7,  16'h0038, 0, 0, 0);
    vecs[4]  = mk(2'b10, 1, 1, 16'h1234, 8'd55,  1, 8'hAA, 4'd9,  16'h0000, 0, 0, 1);
    vecs[5]  = mk(2'b00, 1, 0, 16'h0000, 8'd100, 0, 8'h00, 4'd0,  16'h8000, 0, 0, 0);
    vecs[6]  = mk(2'b00, 1, 0, 16'h0001, 8'd10,  0, 8'h00, 4'd0,  16'h8000, 0, 1, 0);
    vecs[7]  = mk(2'b00, 0, 0, 16'h4000, 8'd0,   0, 8'h00, 4'd0,  16'h0000, 0, 1, 0);
    vecs[8]  = mk(2'b00, 0, 0, 16'h4000, 8'd1,   0, 8'h00, 4'd0,  16'h0080, 0, 0, 0);
    vecs[9]  = mk(2'b00, 1, 0, 16'h4000, 8'd254, 0, 8'h00, 4'd0,  16'hFF00, 0, 0, 0);
    vecs[10] = mk(2'b00, 1, 0, 16'h8000, 8'd254, 0, 8'h00, 4'd0,  16'hFF80, 1, 0, 0);
    vecs[11] = mk(2'b00, 0, 0, 16'h7F00, 8'd127, 0, 8'h00, 4'd0,  16'h3FFE, 0, 0, 0);
    vecs[14] = mk(2'b00, 0, 0, 16'h0005, 8'd20,  0, 8'h00, 4'd0,  16'h0420, 0, 0, 0);
    vecs[15] = mk(2'b01, 0, 0, 16'h0000, 8'd0,   1, 8'h00, 4'd14, 16'h007E, 1, 0, 0);
    vecs[16] = mk(2'b01, 1, 0, 16'h0000, 8'd0,   0, 8'h78, 4'd15, 16'h00FE, 1, 0, 0);
    vecs[17] = mk(2'b01, 0, 0, 16'h0000, 8'd0,   0, 8'h70, 4'd15, 16'h007E, 0, 0, 0);
    vecs[18] = mk(2'b01, 1, 0, 16'h0000, 8'd0,   0, 8'h01, 4'd5,  16'h0080, 0, 1, 0);
    vecs[19] = mk(2'b01, 1, 0, 16'h0000, 8'd0,   0, 8'h00, 4'd3,  16'h0080, 0, 0, 0);
    vecs[20] = mk(2'b11, 1, 0, 16'h0000, 8'd0,   1, 8'hA5, 4'd2,  16'h01A5, 0, 0, 0);
    vecs[21] = mk(2'b01, 0, 0, 16'h0000, 8'd0,   0, 8'h05, 4'd9,  16'h002A, 0, 0, 0);

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_in('0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_state", 32'({out_valid, out_r, sat_count}), 32'(0));
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);

    // Vector table: single beats, two-cycle latency, counter follow-up
    for (int i = 0; i < int'(NV); i++) begin
      set_in(vecs[i].b); in_valid = 1'b1; out_ready = 1'b1;
      #1; check("tbl_in_ready", 32'(in_ready), 32'(1));
      @(negedge clk); in_valid = 1'b0;
      #1; check("tbl_lat1", 32'(out_valid), 32'(0));
      @(negedge clk); #1;
      check($sformatf("tbl%0d", i), 32'({out_valid, out_r}), 32'({1'b1, vecs[i].r}));
      if (vecs[i].r.ovf) exp_sat = sat_inc(exp_sat);
      @(negedge clk); #1;
      check($sformatf("tbl%0d_sat", i), 32'(sat_count), 32'(exp_sat));
      @(negedge clk);
    end

    // Four back-to-back beats with a three-cycle downstream stall
    sb[0] = vecs[0].b; sb[1] = vecs[2].b; sb[2] = vecs[20].b; sb[3] = vecs[10].b;
    k = 0; prev_stall = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      in_valid  = (k < 4);
      if (k < 4) set_in(sb[k]);
      #1;
      if (cyc == 2) begin
        check("stall_in_ready", 32'(in_ready), 32'(0));
        check("stall_buffered", 32'(k), 32'(2));
      end
      if (cyc == 4) check("stall_release", 32'(in_ready), 32'(1));
      acc = in_valid && in_ready;
      tick((k < 4) ? model(sb[k]) : res_t'('0));
      if (acc) k++;
    end
    check("stall_all_out", 32'(q.size()), 32'(0));
    check("stall_all_in", 32'(k), 32'(4));

    // Reset while two beats are in flight
    out_ready = 1'b1; in_valid = 1'b1;
    set_in(vecs[1].b); tick(model(vecs[1].b));
    set_in(vecs[0].b); tick(model(vecs[0].b));
    in_valid = 1'b0; out_ready = 1'b0;
    #1; check("midrst_inflight", 32'(out_valid), 32'(1));
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_state", 32'({out_valid, out_r, sat_count}), 32'(0));
    rst = 1'b0; q.delete(); exp_sat = '0; prev_stall = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      #1; check("midrst_no_stale", 32'({out_valid, in_ready}), 32'(1));
      @(negedge clk);
    end

    // Randomized mixed-mode traffic with random backpressure
    for (int i = 0; i < 800; i++) begin
      b = rand_beat();
      set_in(b);
      in_valid  = ($urandom % 4 != 0);
      out_ready = ($urandom % 3 != 0);
      tick(model(b));
    end

    // Overflow burst drives the counter to its ceiling
    b = vecs[1].b;
    for (int i = 0; i < 24; i++) begin
      set_in(b); in_valid = 1'b1; out_ready = 1'b1;
      tick(model(b));
    end

    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick('0);
    check("drain_empty", 32'(q.size()), 32'(0));
    #1; check("sat_ceiling", 32'(sat_count), 32'(sat_max));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
